// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors round logic.
package rps_pkg;

  // Game-state bus encoding; 01 must stay COUNTDOWN for the move generator.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_COUNTDOWN = 2'b01,
    ST_REVEAL    = 2'b10,
    ST_DONE      = 2'b11
  } state_t;

  localparam logic [1:0] MV_ROCK     = 2'b00;
  localparam logic [1:0] MV_PAPER    = 2'b01;
  localparam logic [1:0] MV_SCISSORS = 2'b10;
  localparam logic [1:0] MV_NONE     = 2'b11;

  localparam logic [1:0] OC_DRAW    = 2'b00;
  localparam logic [1:0] OC_WIN     = 2'b01;
  localparam logic [1:0] OC_LOSE    = 2'b10;
  localparam logic [1:0] OC_FORFEIT = 2'b11;

  // The generator can emit 11; it is treated as rock.
  function automatic logic [1:0] sanitize_move(input logic [1:0] mv);
    return (mv == MV_NONE) ? MV_ROCK : mv;
  endfunction

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: (player, computer) -> outcome.
module rps_judge
  import rps_pkg::*;
(
  input  logic [1:0] ply_move,
  input  logic [1:0] com_move,
  output logic [1:0] outcome_c
);

  logic [1:0] com_s;
  logic [2:0] diff;

  // d = (ply - com) mod 3, then map to outcome; no move is a forfeit.
  always_comb begin
    com_s     = sanitize_move(com_move);
    diff      = 3'(ply_move) + 3'd3 - 3'(com_s);
    if (diff >= 3'd3) diff = diff - 3'd3;
    outcome_c = OC_DRAW;
    if (ply_move == MV_NONE) begin
      outcome_c = OC_FORFEIT;
    end else begin
      case (diff)
        3'd1:    outcome_c = OC_WIN;
        3'd2:    outcome_c = OC_LOSE;
        default: outcome_c = OC_DRAW;
      endcase
    end
  end

endmodule

// File: rtl/rps_round_ctrl.sv
// Round sequencer: countdown, player capture, reveal, judging and scores.
module rps_round_ctrl
  import rps_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 100_000_000,
  parameter int unsigned COUNT_SECS = 3,
  parameter int unsigned MAX_SCORE  = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       player_valid,
  input  logic [1:0] player_move,
  input  logic [1:0] com_result,
  output logic [1:0] state,
  output logic [2:0] sec_left,
  output logic [1:0] com_move,
  output logic [1:0] ply_move,
  output logic [1:0] outcome,
  output logic       result_valid,
  output logic [3:0] win_cnt,
  output logic [3:0] lose_cnt,
  output logic [3:0] draw_cnt,
  output logic       game_over
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t            st;
  logic [TICK_W-1:0] tick;
  logic [1:0]        com_s;
  logic [1:0]        judge_c;
  logic [3:0]        win_nx_c;
  logic [3:0]        lose_nx_c;
  logic [3:0]        draw_nx_c;

  assign state = st;
  assign com_s = sanitize_move(com_result);

  rps_judge u_judge (
    .ply_move  (ply_move),
    .com_move  (com_s),
    .outcome_c (judge_c)
  );

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'(MAX_SCORE)) ? v : v + 4'd1;
  endfunction

  // Scores as they would stand after judging the current reveal.
  always_comb begin
    win_nx_c  = win_cnt;
    lose_nx_c = lose_cnt;
    draw_nx_c = draw_cnt;
    case (judge_c)
      OC_WIN:  win_nx_c  = sat_inc(win_cnt);
      OC_DRAW: draw_nx_c = sat_inc(draw_cnt);
      default: lose_nx_c = sat_inc(lose_cnt);
    endcase
  end

  // Round FSM with tick divider; abort overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= ST_IDLE;
      tick         <= '0;
      sec_left     <= '0;
      com_move     <= MV_ROCK;
      ply_move     <= MV_NONE;
      outcome      <= OC_DRAW;
      result_valid <= 1'b0;
      win_cnt      <= '0;
      lose_cnt     <= '0;
      draw_cnt     <= '0;
      game_over    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (abort) begin
        st        <= ST_IDLE;
        tick      <= '0;
        sec_left  <= '0;
        ply_move  <= MV_NONE;
        win_cnt   <= '0;
        lose_cnt  <= '0;
        draw_cnt  <= '0;
        game_over <= 1'b0;
      end else begin
        case (st)
          ST_IDLE: begin
            if (start) begin
              st       <= ST_COUNTDOWN;
              sec_left <= 3'(COUNT_SECS);
              tick     <= '0;
              ply_move <= MV_NONE;
            end
          end
          ST_COUNTDOWN: begin
            if (player_valid && (player_move != MV_NONE)) ply_move <= player_move;
            if (tick == TICK_W'(TICK_DIV - 1)) begin
              tick <= '0;
              if (sec_left == 3'd1) begin
                st       <= ST_REVEAL;
                sec_left <= '0;
              end else begin
                sec_left <= sec_left - 3'd1;
              end
            end else begin
              tick <= tick + TICK_W'(1);
            end
          end
          ST_REVEAL: begin
            st           <= ST_DONE;
            com_move     <= com_s;
            outcome      <= judge_c;
            result_valid <= 1'b1;
            win_cnt      <= win_nx_c;
            lose_cnt     <= lose_nx_c;
            draw_cnt     <= draw_nx_c;
            game_over    <= (win_nx_c == 4'(MAX_SCORE)) || (lose_nx_c == 4'(MAX_SCORE));
          end
          ST_DONE: begin
            if (start) begin
              st       <= ST_COUNTDOWN;
              sec_left <= 3'(COUNT_SECS);
              tick     <= '0;
              ply_move <= MV_NONE;
              if (game_over) begin
                win_cnt   <= '0;
                lose_cnt  <= '0;
                draw_cnt  <= '0;
                game_over <= 1'b0;
              end
            end
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Self-checking bench for rps_round_ctrl with a behavioural round model.
module tb_rps_round_ctrl;

  localparam int TD = 4;
  localparam int CS = 3;
  localparam int MS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       player_valid = 1'b0;
  logic [1:0] player_move = 2'b11;
  logic [1:0] com_result = 2'b00;
  logic [1:0] state, com_move, ply_move, outcome;
  logic [2:0] sec_left;
  logic       result_valid, game_over;
  logic [3:0] win_cnt, lose_cnt, draw_cnt;

  logic [1:0] j_ply = 2'b00;
  logic [1:0] j_com = 2'b00;
  logic [1:0] j_out;

  int  checks = 0;
  int  failures = 0;
  bit  cmp_en = 1'b0;

  rps_round_ctrl #(.TICK_DIV(TD), .COUNT_SECS(CS), .MAX_SCORE(MS)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .player_valid (player_valid),
    .player_move  (player_move),
    .com_result   (com_result),
    .state        (state),
    .sec_left     (sec_left),
    .com_move     (com_move),
    .ply_move     (ply_move),
    .outcome      (outcome),
    .result_valid (result_valid),
    .win_cnt      (win_cnt),
    .lose_cnt     (lose_cnt),
    .draw_cnt     (draw_cnt),
    .game_over    (game_over)
  );

  rps_judge u_judge_chk (
    .ply_move  (j_ply),
    .com_move  (j_com),
    .outcome_c (j_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference judge: who beats whom, expressed as a victim table.
  function automatic int victim_of(input int mv);
    case (mv)
      0:       return 2;  // rock crushes scissors
      1:       return 0;  // paper covers rock
      default: return 1;  // scissors cut paper
    endcase
  endfunction

  function automatic int judge_ref(input int p, input int c);
    int cs;
    cs = (c == 3) ? 0 : c;
    if (p == 3) return 3;
    if (p == cs) return 0;
    if (victim_of(p) == cs) return 1;
    return 2;
  endfunction

  // Behavioural model state (state codes as seen on the bus).
  int m_state = 0, m_elapsed = 0, m_sec = 0, m_com = 0, m_ply = 3, m_out = 0;
  int m_rv = 0, m_win = 0, m_lose = 0, m_draw = 0, m_go = 0;

  task automatic model_reset();
    m_state = 0; m_elapsed = 0; m_sec = 0; m_com = 0; m_ply = 3; m_out = 0;
    m_rv = 0; m_win = 0; m_lose = 0; m_draw = 0; m_go = 0;
  endtask

  task automatic model_begin_round();
    m_state = 1; m_elapsed = 0; m_sec = CS; m_ply = 3;
  endtask

  task automatic model_step();
    m_rv = 0;
    if (abort) begin
      m_state = 0; m_sec = 0; m_ply = 3;
      m_win = 0; m_lose = 0; m_draw = 0; m_go = 0;
    end else begin
      case (m_state)
        0: if (start) model_begin_round();
        1: begin
          if (player_valid && player_move != 2'b11) m_ply = int'(player_move);
          m_elapsed++;
          if (m_elapsed == CS * TD) begin
            m_state = 2;
            m_sec = 0;
          end else begin
            m_sec = CS - m_elapsed / TD;
          end
        end
        2: begin
          m_com = (com_result == 2'b11) ? 0 : int'(com_result);
          m_out = judge_ref(m_ply, m_com);
          m_rv = 1;
          if (m_out == 1) m_win = (m_win < MS) ? m_win + 1 : MS;
          else if (m_out == 0) m_draw = (m_draw < MS) ? m_draw + 1 : MS;
          else m_lose = (m_lose < MS) ? m_lose + 1 : MS;
          m_go = (m_win == MS || m_lose == MS) ? 1 : 0;
          m_state = 3;
        end
        default: if (start) begin
          if (m_go != 0) begin
            m_win = 0; m_lose = 0; m_draw = 0; m_go = 0;
          end
          model_begin_round();
        end
      endcase
    end
  endtask

  // Model advances on every clock edge or async reset.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Compare every output against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && !rst) begin
        check("state", int'(state), m_state);
        check("sec_left", int'(sec_left), m_sec);
        check("com_move", int'(com_move), m_com);
        check("ply_move", int'(ply_move), m_ply);
        check("outcome", int'(outcome), m_out);
        check("result_valid", int'(result_valid), m_rv);
        check("win_cnt", int'(win_cnt), m_win);
        check("lose_cnt", int'(lose_cnt), m_lose);
        check("draw_cnt", int'(draw_cnt), m_draw);
        check("game_over", int'(game_over), m_go);
      end
    end
  end

  // Drive one cycle of inputs, returning at the following falling edge.
  task automatic cyc(input logic s, input logic a, input logic pv,
                     input logic [1:0] pm, input logic [1:0] cr);
    start = s; abort = a; player_valid = pv; player_move = pm; com_result = cr;
    @(negedge clk);
  endtask

  // Full countdown plus reveal; player moves at countdown cycles t1 and t2.
  task automatic countdown(input int t1, input logic [1:0] m1, input int t2,
                           input logic [1:0] m2, input logic [1:0] cr);
    for (int i = 0; i < CS * TD; i++)
      cyc(1'b0, 1'b0, (i == t1) || (i == t2), (i == t2) ? m2 : m1, 2'($urandom));
    cyc(1'b0, 1'b0, 1'($urandom), 2'($urandom), cr);
  endtask

  task automatic round(input int t1, input logic [1:0] m1, input int t2,
                       input logic [1:0] m2, input logic [1:0] cr);
    cyc(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    countdown(t1, m1, t2, m2, cr);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_state", int'(state), 0);
    check("rst_ply", int'(ply_move), 3);
    check("rst_scores", int'(win_cnt) + int'(lose_cnt) + int'(draw_cnt), 0);

    // Round 1: paper vs rock, move entered at countdown cycle 5.
    cyc(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    check("r1_state_cd", int'(state), 1);
    check("r1_sec3", int'(sec_left), 3);
    for (int i = 0; i < CS * TD; i++) begin
      cyc(1'b0, 1'b0, i == 4, 2'b01, 2'b00);
      if (i == 3) check("r1_sec2", int'(sec_left), 2);
      if (i == 7) check("r1_sec1", int'(sec_left), 1);
      if (i == 10) check("r1_still_cd", int'(state), 1);
    end
    check("r1_reveal", int'(state), 2);
    check("r1_sec0", int'(sec_left), 0);
    cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b00);
    check("r1_done", int'(state), 3);
    check("r1_outcome", int'(outcome), 1);
    check("r1_rv", int'(result_valid), 1);
    check("r1_win", int'(win_cnt), 1);
    cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b00);
    check("r1_rv_pulse", int'(result_valid), 0);

    // Round 2: no player move -> forfeit.
    round(-1, 2'b00, -1, 2'b00, 2'b10);
    check("r2_outcome", int'(outcome), 3);
    check("r2_lose", int'(lose_cnt), 1);
    check("r2_com", int'(com_move), 2);

    // Round 3: generator emits 11, treated as rock.
    round(3, 2'b00, -1, 2'b00, 2'b11);
    check("r3_com", int'(com_move), 0);
    check("r3_outcome", int'(outcome), 0);
    check("r3_draw", int'(draw_cnt), 1);
    round(2, 2'b00, 7, 2'b10, 2'b11);
    check("r3_last_move", int'(ply_move), 2);
    check("r3_lose2", int'(lose_cnt), 2);
    check("r3_go", int'(game_over), 1);

    // Round 4: start after game over clears scores.
    cyc(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    check("r4_state", int'(state), 1);
    check("r4_cleared", int'(win_cnt) + int'(lose_cnt) + int'(draw_cnt), 0);
    check("r4_go_clr", int'(game_over), 0);
    countdown(5, 2'b10, -1, 2'b00, 2'b01);
    check("r4_win1", int'(win_cnt), 1);
    round(0, 2'b10, -1, 2'b00, 2'b01);
    check("r4_win2", int'(win_cnt), 2);
    check("r4_go", int'(game_over), 1);
    for (int k = 0; k < 3; k++) round(1, 2'b01, -1, 2'b00, 2'b01);
    check("r4_draw_sat", int'(draw_cnt), 2);
    check("r4_go_draws", int'(game_over), 0);

    // Round 5: start+abort together mid-countdown.
    cyc(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    repeat (5) cyc(1'b0, 1'b0, 1'b1, 2'b01, 2'b00);
    cyc(1'b1, 1'b1, 1'b0, 2'b11, 2'b00);
    check("r5_abort_state", int'(state), 0);
    check("r5_abort_draw", int'(draw_cnt), 0);
    check("r5_abort_ply", int'(ply_move), 3);
    check("r5_abort_rv", int'(result_valid), 0);
    cyc(1'b0, 1'b0, 1'b0, 2'b11, 2'b00);
    check("r5_abort_rv2", int'(result_valid), 0);

    // Async reset between clock edges.
    cyc(1'b1, 1'b0, 1'b0, 2'b11, 2'b00);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 2'b10, 2'b00);
    start = 1'b0; player_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_sec", int'(sec_left), 0);
    check("arst_com", int'(com_move), 0);
    check("arst_ply", int'(ply_move), 3);
    #1 rst = 1'b0;
    @(negedge clk);

    // Exhaustive judge table, with a few literal anchors.
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) begin
        j_ply = 2'(p); j_com = 2'(c);
        #1;
        check("judge_table", int'(j_out), judge_ref(p, c));
      end
    end
    j_ply = 2'b10; j_com = 2'b01; #1 check("judge_sc_pa", int'(j_out), 1);
    j_ply = 2'b00; j_com = 2'b01; #1 check("judge_ro_pa", int'(j_out), 2);
    j_ply = 2'b11; j_com = 2'b00; #1 check("judge_none", int'(j_out), 3);
    @(negedge clk);

    // Randomized play against the model.
    repeat (3000)
      cyc(($urandom % 6) == 0, ($urandom % 97) == 0, ($urandom % 3) == 0,
          2'($urandom), 2'($urandom));

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
